dense_neuron_seq: RTL and testbench

//   Sequencer for one dense-layer neuron: streams activations, fetches weights from
//   a 1-cycle-latency weight ROM, and drives the external mac_shifter stage to accumulate.

---
 rtl/dense_pkg.sv | 11 +
 rtl/relu_saturate.sv | 24 ++
 rtl/dense_neuron_seq.sv | 120 ++++++++++++
 tb/tb_dense_neuron_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared types and constants for the dense neuron sequencer.
package dense_pkg;
  localparam int SHIFT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUTPUT
  } state_t;
endpackage

// File: rtl/relu_saturate.sv
// Combinational 2N -> N reduction: optional ReLU, then signed saturation.
module relu_saturate
  import dense_pkg::*;
#(
  parameter int N       = 16,
  parameter bit RELU_EN = 1'b1
) (
  input  logic signed [2*N-1:0] sum,
  output logic signed [N-1:0]   res
);
  localparam logic signed [2*N-1:0] MAXV = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] MINV = {{(N+1){1'b1}}, {(N-1){1'b0}}};

  // clamp the wide sum into the N-bit signed range
  always_comb begin
    res = sum[N-1:0];
    if (RELU_EN && sum[2*N-1])
      res = '0;
    else if (sum > MAXV)
      res = MAXV[N-1:0];
    else if (sum < MINV)
      res = MINV[N-1:0];
  end
endmodule

// File: rtl/dense_neuron_seq.sv
// Dense-layer neuron sequencer: streams activations against ROM weights
// through an external registered MAC, then saturates and hands off the result.
module dense_neuron_seq
  import dense_pkg::*;
#(
  parameter int N          = 16,
  parameter int NUM_INPUTS = 784,
  parameter int ADDR_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [SHIFT_W-1:0]    shift_i,
  input  logic signed [2*N-1:0] bias_i,
  input  logic                  act_valid_i,
  input  logic signed [N-1:0]   act_i,
  output logic                  act_ready_o,
  output logic                  w_rd_o,
  output logic [ADDR_W-1:0]     w_addr_o,
  input  logic signed [N-1:0]   w_data_i,
  output logic                  mac_en_o,
  output logic signed [N-1:0]   mac_value_o,
  output logic signed [N-1:0]   mac_mult_o,
  output logic signed [2*N-1:0] mac_add_o,
  output logic [SHIFT_W-1:0]    mac_shift_o,
  input  logic signed [2*N-1:0] mac_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic signed [N-1:0]   out_o,
  output logic                  busy_o,
  output logic                  done_o
);
  // one extra bit so the count can sit at NUM_INPUTS without wrapping
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] NUM  = CNT_W'(NUM_INPUTS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUTS - 1);

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt;
  logic                  pend;    // product issued to the MAC this cycle
  logic                  first;   // next product takes the bias as addend
  logic                  drain;   // second DRAIN cycle
  logic signed [N-1:0]   act_q;
  logic [SHIFT_W-1:0]    shift_q;
  logic signed [2*N-1:0] bias_q;
  logic signed [N-1:0]   sat;
  logic signed [N-1:0]   out_q;
  logic                  accept;

  assign act_ready_o = (state == ACCUM) && (cnt < NUM);
  assign accept      = act_valid_i & act_ready_o;
  assign w_rd_o      = accept;
  assign w_addr_o    = accept ? cnt[ADDR_W-1:0] : '0;

  // weight arrives one cycle after the read, so the MAC fires one cycle after accept
  assign mac_en_o    = pend;
  assign mac_value_o = pend ? act_q : '0;
  assign mac_mult_o  = pend ? w_data_i : '0;
  assign mac_add_o   = pend ? (first ? bias_q : mac_i) : '0;
  assign mac_shift_o = shift_q;

  assign out_valid_o = (state == OUTPUT);
  assign out_o       = out_q;
  assign busy_o      = (state != IDLE);
  assign done_o      = out_valid_o & out_ready_i;

  relu_saturate #(.N(N), .RELU_EN(RELU_EN)) u_sat (
    .sum (mac_i),
    .res (sat)
  );

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  // next-state: two fixed DRAIN cycles let the last product land in mac_i
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = ACCUM;
      ACCUM:   if (accept && cnt == LAST) state_nx = DRAIN;
      DRAIN:   if (drain) state_nx = OUTPUT;
      OUTPUT:  if (out_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // datapath: operand capture, counters, result latch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt     <= '0;
      pend    <= 1'b0;
      first   <= 1'b0;
      drain   <= 1'b0;
      act_q   <= '0;
      shift_q <= '0;
      bias_q  <= '0;
      out_q   <= '0;
    end else begin
      pend  <= accept;
      drain <= (state == DRAIN) && !drain;
      if (accept) begin
        act_q <= act_i;
        cnt   <= cnt + 1'b1;
      end
      if (pend) first <= 1'b0;
      if (state == IDLE && start_i) begin
        cnt     <= '0;
        first   <= 1'b1;
        shift_q <= shift_i;
        bias_q  <= bias_i;
      end
      // mac_i is final on the second DRAIN cycle
      if (state == DRAIN && drain) out_q <= sat;
    end
  end
endmodule

// File: tb/tb_dense_neuron_seq.sv
// Bench: two sequencers (ReLU on / off) each wrapped with a ROM and a shift-MAC,
// compared against a plain-arithmetic dot-product model.
module tb_dense_neuron_seq;
  localparam int N  = 16;
  localparam int NI = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                start, act_valid, out_ready;
  logic [5:0]          shift;
  logic signed [31:0]  bias;
  logic signed [15:0]  act;

  logic                act_ready [2];
  logic                w_rd      [2];
  logic [AW-1:0]       w_addr    [2];
  logic signed [15:0]  w_data    [2];
  logic                mac_en    [2];
  logic signed [15:0]  mac_value [2];
  logic signed [15:0]  mac_mult  [2];
  logic signed [31:0]  mac_add   [2];
  logic [5:0]          mac_shift [2];
  logic signed [31:0]  mac_o     [2];
  logic                out_valid [2];
  logic signed [15:0]  out       [2];
  logic                busy      [2];
  logic                done      [2];

  logic signed [15:0]  wrom [NI];
  int acts [NI];
  int wts  [NI];

  int n_chk  = 0;
  int n_pass = 0;
  int men_cnt = 0;
  int done_cnt = 0;

  for (genvar g = 0; g < 2; g++) begin : g_env
    dense_neuron_seq #(.N(N), .NUM_INPUTS(NI), .RELU_EN(g == 0)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .shift_i     (shift),
      .bias_i      (bias),
      .act_valid_i (act_valid),
      .act_i       (act),
      .act_ready_o (act_ready[g]),
      .w_rd_o      (w_rd[g]),
      .w_addr_o    (w_addr[g]),
      .w_data_i    (w_data[g]),
      .mac_en_o    (mac_en[g]),
      .mac_value_o (mac_value[g]),
      .mac_mult_o  (mac_mult[g]),
      .mac_add_o   (mac_add[g]),
      .mac_shift_o (mac_shift[g]),
      .mac_i       (mac_o[g]),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready),
      .out_o       (out[g]),
      .busy_o      (busy[g]),
      .done_o      (done[g])
    );

    always @(posedge clk) if (w_rd[g]) w_data[g] <= wrom[w_addr[g]];

    always @(posedge clk or negedge rst_n)
      if (!rst_n) mac_o[g] <= '0;
      else if (mac_en[g])
        mac_o[g] <= ((mac_value[g] * mac_mult[g]) >>> mac_shift[g]) + mac_add[g];
  end

  always @(posedge clk) begin
    if (mac_en[0]) men_cnt <= men_cnt + 1;
    if (done[0])   done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint ref_sum(input int sh, input longint b);
    longint s = b;
    for (int k = 0; k < NI; k++) s += (longint'(acts[k]) * longint'(wts[k])) >>> sh;
    return s;
  endfunction

  function automatic longint ref_sat(input longint s, input bit relu);
    if (relu && s < 0) return 0;
    if (s > 32767)     return 32767;
    if (s < -32768)    return -32768;
    return s;
  endfunction

  task automatic load(input int a0, a1, a2, a3, w0, w1, w2, w3);
    acts = '{a0, a1, a2, a3};
    wts  = '{w0, w1, w2, w3};
    for (int k = 0; k < NI; k++) wrom[k] = 16'(wts[k]);
  endtask

  // one full neuron: start, stream, optional output stall, handshake
  task automatic run(input string tag, input int sh, input longint b,
                     input bit gaps, input int hold);
    longint s, e0, e1;
    int m0, d0, k, cyc;
    bit hs;
    s  = ref_sum(sh, b);
    e0 = ref_sat(s, 1'b1);
    e1 = ref_sat(s, 1'b0);
    m0 = men_cnt;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; shift = 6'(sh); bias = 32'(b);
    @(negedge clk);
    start = 1'b0;
    k = 0; cyc = 0;
    while (k < NI && cyc < 200) begin
      act_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      act = 16'(acts[k]);
      #1 hs = act_valid && act_ready[0];
      @(negedge clk);
      if (hs) k++;
      cyc++;
    end
    act_valid = 1'b0;
    if (k < NI) chk({tag, "_feed_timeout"}, k, NI);
    out_ready = (hold == 0);
    cyc = 0;
    while (!out_valid[0] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_valid"}, out_valid[0], 1);
    for (int i = 0; i < hold; i++) begin
      start = (i == 2);
      #1;
      chk({tag, "_stall_out"}, out[0], e0);
      chk({tag, "_stall_busy"}, busy[0], 1);
      chk({tag, "_stall_valid"}, out_valid[0], 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    start = 1'b1;
    #1;
    chk({tag, "_done"}, done[0], 1);
    chk({tag, "_out_relu"}, out[0], e0);
    chk({tag, "_out_norelu"}, out[1], e1);
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    #1;
    chk({tag, "_idle_busy"}, busy[0], 0);
    chk({tag, "_done_low"}, done[0], 0);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_mac_en_cnt"}, men_cnt - m0, NI);
  endtask

  initial begin
    int k, cyc;
    bit hs;
    start = 0; act_valid = 0; out_ready = 0; shift = 0; bias = 0; act = 0;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy[0], 0);
    chk("rst_ready", act_ready[0], 0);
    chk("rst_mac_en", mac_en[0], 0);
    chk("rst_mac_shift", mac_shift[0], 0);
    chk("rst_valid", out_valid[0], 0);
    chk("rst_out", out[0], 0);
    chk("rst_done", done[0], 0);
    rst_n = 1'b1;

    load(1, 2, 3, 4, 1, 1, 1, 1);
    run("basic", 0, 10, 1'b0, 0);
    load(-100, -100, -100, -100, 100, 100, 100, 100);
    run("neg", 0, 0, 1'b0, 0);
    load(200, 200, 200, 200, 200, 200, 200, 200);
    run("sat_pos", 0, 0, 1'b0, 0);
    run("shift4", 4, 0, 1'b0, 0);
    load(1, 2, 3, 4, 1, 1, 1, 1);
    run("gaps", 0, 10, 1'b1, 0);
    run("stall", 0, 10, 1'b0, 5);

    for (int r = 0; r < 6; r++) begin
      load(int'($urandom_range(4000)) - 2000, int'($urandom_range(4000)) - 2000,
           int'($urandom_range(4000)) - 2000, int'($urandom_range(4000)) - 2000,
           int'($urandom_range(4000)) - 2000, int'($urandom_range(4000)) - 2000,
           int'($urandom_range(4000)) - 2000, int'($urandom_range(4000)) - 2000);
      run($sformatf("rnd%0d", r), int'($urandom_range(3)),
          longint'(int'($urandom_range(200000)) - 100000),
          1'($urandom_range(1)), int'($urandom_range(3)));
    end

    // abort part-way through accumulation
    load(7, 7, 7, 7, 9, 9, 9, 9);
    @(negedge clk);
    start = 1'b1; shift = 0; bias = 32'sd5000;
    @(negedge clk);
    start = 1'b0;
    k = 0; cyc = 0;
    while (k < 2 && cyc < 50) begin
      act_valid = 1'b1;
      act = 16'(acts[k]);
      #1 hs = act_ready[0];
      @(negedge clk);
      if (hs) k++;
      cyc++;
    end
    act_valid = 1'b0;
    chk("mid_mac_en_before", mac_en[0], 1);
    rst_n = 1'b0;
    #1;
    chk("mid_mac_en", mac_en[0], 0);
    chk("mid_busy", busy[0], 0);
    chk("mid_ready", act_ready[0], 0);
    chk("mid_out", out[0], 0);
    chk("mid_mac_add", mac_add[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    load(1, 2, 3, 4, 1, 1, 1, 1);
    run("post_rst", 0, 10, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
